// File: rtl/single_cpu_board_core.sv
// Board top: single-cycle 16-bit teaching CPU, step-rate divider and a six-digit scanned display.
// Optional build macro HALT_DP_EN lights every decimal point while the CPU is halted.
module single_cpu_board_core #(
    parameter int STEP_DIV = 1,
    parameter int SCAN_DIV = 4
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] Switch,
    output logic [7:0] Segs,
    output logic [5:0] En
);
    localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    function automatic logic [15:0] rom(input logic [7:0] addr);
        case (addr)
            8'd0:    rom = 16'h4201;
            8'd1:    rom = 16'h4401;
            8'd2:    rom = 16'h480A;
            8'd3:    rom = 16'h0650;
            8'd4:    rom = 16'h0280;
            8'd5:    rom = 16'h04C0;
            8'd6:    rom = 16'h493F;
            8'd7:    rom = 16'h6801;
            8'd8:    rom = 16'h7003;
            default: rom = 16'hF000;
        endcase
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    endfunction

    function automatic logic signed [15:0] sext6(input logic [5:0] v);
        sext6 = {{10{v[5]}}, v};
    endfunction

    logic [STEP_W-1:0]   step_cnt;
    logic                step_tick;
    logic [SCAN_W-1:0]   scan_cnt;
    logic [2:0]          dig;
    logic [7:0]          pc;
    logic                halted;
    logic [15:0]         regs [8];

    logic [15:0]         instr;
    logic [3:0]          op;
    logic [2:0]          rd, rs, rt;
    logic signed [15:0]  simm;
    logic [15:0]         va, vb, vd;
    logic [15:0]         alu_res;
    logic                wr_en;
    logic [7:0]          pc_next;
    logic                halt_next;
    logic                do_step;

    assign step_tick = (step_cnt == STEP_W'(STEP_DIV - 1));
    assign do_step   = step_tick & Switch[5] & ~halted;

    always_ff @(posedge CLK) begin
        if (Reset || step_tick) step_cnt <= '0;
        else                    step_cnt <= step_cnt + 1'b1;
    end

    // Decode and execute the instruction at pc in one cycle.
    always_comb begin
        instr     = rom(pc);
        op        = instr[15:12];
        rd        = instr[11:9];
        rs        = instr[8:6];
        rt        = instr[5:3];
        simm      = sext6(instr[5:0]);
        va        = regs[rs];
        vb        = regs[rt];
        vd        = regs[rd];
        alu_res   = 16'h0000;
        wr_en     = 1'b0;
        pc_next   = pc + 8'd1;
        halt_next = halted;
        case (op)
            4'h0: begin alu_res = va + vb; wr_en = 1'b1; end
            4'h1: begin alu_res = va - vb; wr_en = 1'b1; end
            4'h2: begin alu_res = va & vb; wr_en = 1'b1; end
            4'h3: begin alu_res = va | vb; wr_en = 1'b1; end
            4'h4: begin alu_res = va + simm; wr_en = 1'b1; end
            4'h6: if (vd == va) pc_next = pc + 8'd1 + simm[7:0];
            4'h7: pc_next = instr[7:0];
            4'hF: begin pc_next = pc; halt_next = 1'b1; end
            default: ;
        endcase
    end

    // r0 is never written, so its reset value keeps it reading as zero.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc     <= 8'h00;
            halted <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
        end else if (do_step) begin
            pc     <= pc_next;
            halted <= halt_next;
            if (wr_en && rd != 3'd0) regs[rd] <= alu_res;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            scan_cnt <= '0;
            dig      <= 3'd0;
        end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            dig      <= (dig == 3'd5) ? 3'd0 : dig + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    logic [23:0] disp_word;
    logic [5:0]  disp_blank;
    logic [3:0]  nib;
    logic        dp;

    always_comb begin
        disp_blank = 6'b000000;
        case (Switch[1:0])
            2'b00:   disp_word = {pc, instr};
            2'b01: begin
                disp_word  = {1'b0, Switch[4:2], 4'h0, regs[Switch[4:2]]};
                disp_blank = 6'b010000;
            end
            2'b10:   disp_word = {pc, alu_res};
            default: disp_word = {regs[1][7:0], regs[2][7:0], regs[3][7:0]};
        endcase
        nib = disp_word[{dig, 2'b00} +: 4];
`ifdef HALT_DP_EN
        dp = ~halted;
`else
        dp = 1'b1;
`endif
    end

    // Outputs are registered, so the display trails the digit index by one clock.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            Segs <= 8'hFF;
            En   <= 6'b111111;
        end else begin
            En   <= ~(6'b000001 << dig);
            Segs <= {dp, disp_blank[dig] ? 7'h7F : glyph(nib)};
        end
    end
endmodule

// File: tb/tb_single_cpu_board_core.sv
// Self-checking bench for single_cpu_board_core: directed program checks plus randomized
// switch/reset stimulus compared every clock against an instruction-level model.
module tb_single_cpu_board_core;
    localparam int STEP_DIV = 1;
    localparam int SCAN_DIV = 4;
`ifdef HALT_DP_EN
    localparam bit DP_ON_HALT = 1'b1;
`else
    localparam bit DP_ON_HALT = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic [5:0] Switch = 6'b000000;
    logic [7:0] Segs;
    logic [5:0] En;

    int asserts = 0;
    int fails = 0;

    single_cpu_board_core #(.STEP_DIV(STEP_DIV), .SCAN_DIV(SCAN_DIV)) dut (
        .CLK(CLK), .Reset(Reset), .Switch(Switch), .Segs(Segs), .En(En)
    );

    always #5 CLK = ~CLK;

    // Reference model state
    logic [7:0]  glyph_tab [16];
    logic [15:0] rom_m [256];
    logic [15:0] m_r [8];
    int          m_pc;
    bit          m_halt;
    int          m_n;
    logic [7:0]  exp_segs;
    logic [5:0]  exp_en;
    logic [7:0]  cap [6];
    logic [7:0]  want [6];

    function automatic logic [15:0] enc(int op, int rd, int rs, int low6);
        return 16'((op << 12) | (rd << 9) | (rs << 6) | (low6 & 63));
    endfunction

    function automatic int sext6(int v);
        return ((v & 32) != 0) ? (v & 63) - 64 : (v & 63);
    endfunction

    function automatic logic [15:0] m_alu();
        logic [15:0] ins;
        logic [15:0] a, b;
        ins = rom_m[m_pc];
        a = m_r[int'(ins[8:6])];
        b = m_r[int'(ins[5:3])];
        case (int'(ins[15:12]))
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a + 16'(sext6(int'(ins[5:0])));
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_exec();
        logic [15:0] ins;
        int op, rd, rs;
        ins = rom_m[m_pc];
        op = int'(ins[15:12]);
        rd = int'(ins[11:9]);
        rs = int'(ins[8:6]);
        if (op <= 4) begin
            if (rd != 0) m_r[rd] = m_alu();
            m_pc = (m_pc + 1) & 255;
        end else if (op == 6) begin
            if (m_r[rd] == m_r[rs]) m_pc = (m_pc + 1 + sext6(int'(ins[5:0]))) & 255;
            else                    m_pc = (m_pc + 1) & 255;
        end else if (op == 7) begin
            m_pc = int'(ins[7:0]);
        end else if (op == 15) begin
            m_halt = 1'b1;
        end else begin
            m_pc = (m_pc + 1) & 255;
        end
    endtask

    function automatic logic [7:0] model_digit(int d);
        logic [23:0] w;
        logic [5:0]  bl;
        logic        dpv;
        logic [3:0]  nb;
        int          idx;
        bl  = 6'b000000;
        idx = int'(Switch[4:2]);
        case (Switch[1:0])
            2'b00: w = {8'(m_pc), rom_m[m_pc]};
            2'b01: begin w = {4'(idx), 4'h0, m_r[idx]}; bl = 6'b010000; end
            2'b10: w = {8'(m_pc), m_alu()};
            default: w = {m_r[1][7:0], m_r[2][7:0], m_r[3][7:0]};
        endcase
        dpv = (DP_ON_HALT && m_halt) ? 1'b0 : 1'b1;
        nb  = w[d*4 +: 4];
        return bl[d] ? {dpv, 7'h7F} : {dpv, glyph_tab[nb][6:0]};
    endfunction

    // Advance one clock: predict registered outputs from pre-edge state, then update the model.
    task automatic tick();
        if (Reset) begin
            exp_segs = 8'hFF;
            exp_en   = 6'h3F;
            m_pc     = 0;
            m_halt   = 1'b0;
            m_n      = 0;
            for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
        end else begin
            int d;
            d = (m_n / SCAN_DIV) % 6;
            exp_en   = ~(6'b000001 << d);
            exp_segs = model_digit(d);
            if ((m_n % STEP_DIV) == STEP_DIV - 1 && Switch[5] && !m_halt) model_exec();
            m_n++;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic capture();
        for (int i = 0; i < 6; i++) cap[i] = 8'h00;
        repeat (6 * SCAN_DIV + 1) begin
            tick();
            for (int d = 0; d < 6; d++)
                if (En == ~(6'b000001 << d)) cap[d] = Segs;
        end
    endtask

    task automatic test_reset();
        Switch = 6'b000000;
        do_reset();
        asserts++;
        if (Segs !== 8'hFF) begin fails++; $display("FAIL reset_segs: got %h want ff", Segs); end
        asserts++;
        if (En !== 6'h3F) begin fails++; $display("FAIL reset_en: got %h want 3f", En); end
        tick();
        asserts++;
        if (En !== 6'h3E) begin fails++; $display("FAIL first_digit_en: got %h want 3e", En); end
        asserts++;
        if (Segs !== 8'hF9) begin fails++; $display("FAIL first_digit_segs: got %h want f9", Segs); end
    endtask

    task automatic test_fib_steps();
        do_reset();
        Switch = 6'b111111;
        repeat (3) tick();
        Switch = 6'b011111;
        capture();
        want = '{8'hC0, 8'hC0, 8'hF9, 8'hC0, 8'hF9, 8'hC0};
        for (int d = 0; d < 6; d++) begin
            asserts++;
            if (cap[d] !== want[d]) begin
                fails++; $display("FAIL fib3_digit%0d: got %h want %h", d, cap[d], want[d]);
            end
        end
        Switch = 6'b111111;
        tick();
        Switch = 6'b011111;
        capture();
        want = '{8'hA4, 8'hC0, 8'hF9, 8'hC0, 8'hF9, 8'hC0};
        for (int d = 0; d < 6; d++) begin
            asserts++;
            if (cap[d] !== want[d]) begin
                fails++; $display("FAIL fib4_digit%0d: got %h want %h", d, cap[d], want[d]);
            end
        end
    endtask

    task automatic test_program_run();
        logic [7:0] dpm;
        do_reset();
        Switch = 6'b100001;
        for (int c = 0; c < 70; c++) begin
            tick();
            if (En[3:0] != 4'hF) begin
                asserts++;
                if (Segs[6:0] !== 7'h40) begin
                    fails++; $display("FAIL r0_zero: got %h want 40 (cycle %0d)", Segs[6:0], c);
                end
            end
        end
        dpm = DP_ON_HALT ? 8'h7F : 8'hFF;
        Switch = 6'b101101;
        capture();
        want = '{8'hC0, 8'h90, 8'hC0, 8'hC0, 8'hFF, 8'hB0};
        for (int d = 0; d < 6; d++) begin
            asserts++;
            if (cap[d] !== (want[d] & dpm)) begin
                fails++; $display("FAIL r3_final_digit%0d: got %h want %h", d, cap[d], want[d] & dpm);
            end
        end
        Switch = 6'b000000;
        capture();
        want = '{8'hC0, 8'hC0, 8'hC0, 8'h8E, 8'h90, 8'hC0};
        for (int d = 0; d < 6; d++) begin
            asserts++;
            if (cap[d] !== (want[d] & dpm)) begin
                fails++; $display("FAIL halt_pc_digit%0d: got %h want %h", d, cap[d], want[d] & dpm);
            end
        end
    endtask

    task automatic test_freeze();
        do_reset();
        Switch = 6'b000000;
        repeat (20) tick();
        capture();
        want = '{8'hF9, 8'hC0, 8'hA4, 8'h99, 8'hC0, 8'hC0};
        for (int d = 0; d < 6; d++) begin
            asserts++;
            if (cap[d] !== want[d]) begin
                fails++; $display("FAIL frozen_digit%0d: got %h want %h", d, cap[d], want[d]);
            end
        end
        Switch = 6'b100000;
        tick();
        Switch = 6'b000000;
        capture();
        want = '{8'hF9, 8'hC0, 8'h99, 8'h99, 8'hF9, 8'hC0};
        for (int d = 0; d < 6; d++) begin
            asserts++;
            if (cap[d] !== want[d]) begin
                fails++; $display("FAIL resume_digit%0d: got %h want %h", d, cap[d], want[d]);
            end
        end
    endtask

    task automatic test_scan();
        logic [5:0] en_seq [6];
        en_seq = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
        do_reset();
        Switch = 6'b000000;
        for (int c = 0; c < 12 * SCAN_DIV; c++) begin
            tick();
            asserts++;
            if (En !== en_seq[(c / SCAN_DIV) % 6]) begin
                fails++; $display("FAIL scan_en: got %h want %h (cycle %0d)", En, en_seq[(c / SCAN_DIV) % 6], c);
            end
        end
    endtask

    task automatic test_halt_dp();
        logic want_dp;
        do_reset();
        Switch = 6'b100000;
        tick();
        asserts++;
        if (Segs[7] !== 1'b1) begin fails++; $display("FAIL dp_running: got %b want 1", Segs[7]); end
        repeat (70) tick();
        want_dp = DP_ON_HALT ? 1'b0 : 1'b1;
        for (int m = 0; m < 4; m++) begin
            Switch = {1'b1, 3'b011, 2'(m)};
            for (int c = 0; c < 6 * SCAN_DIV; c++) begin
                tick();
                asserts++;
                if (Segs[7] !== want_dp) begin
                    fails++; $display("FAIL dp_halted: got %b want %b (mode %0d)", Segs[7], want_dp, m);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int it = 0; it < 150; it++) begin
            Switch    = 6'($urandom);
            Switch[5] = ($urandom_range(0, 3) != 0);
            Reset     = ($urandom_range(0, 19) == 0);
            repeat ($urandom_range(1, 40)) begin
                tick();
                asserts++;
                if (Segs !== exp_segs || En !== exp_en) begin
                    fails++;
                    $display("FAIL random_model: got segs %h en %h want segs %h en %h (iter %0d)",
                             Segs, En, exp_segs, exp_en, it);
                end
            end
        end
        Reset = 1'b0;
    endtask

    initial begin
        glyph_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        for (int a = 0; a < 256; a++) rom_m[a] = enc(15, 0, 0, 0);
        rom_m[0] = enc(4, 1, 0, 1);
        rom_m[1] = enc(4, 2, 0, 1);
        rom_m[2] = enc(4, 4, 0, 10);
        rom_m[3] = enc(0, 3, 1, 2 << 3);
        rom_m[4] = enc(0, 1, 2, 0);
        rom_m[5] = enc(0, 2, 3, 0);
        rom_m[6] = enc(4, 4, 4, -1);
        rom_m[7] = enc(6, 4, 0, 1);
        rom_m[8] = 16'((7 << 12) | 3);
        m_pc = 0;
        m_halt = 1'b0;
        m_n = 0;
        for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;

        test_reset();
        test_fib_steps();
        test_program_run();
        test_freeze();
        test_scan();
        test_halt_dp();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule

// File: doc/single_cpu_board_core.md
# single_cpu_board_core

Board-level top for the single-cycle teaching CPU. It contains:
- a minimal 16-bit single-cycle CPU with an 8-register file and a fixed program ROM;
- a step-rate divider;
- a six-digit multiplexed seven-segment driver.

Slide switches select what is displayed and gate execution. The block is the FPGA top: it connects directly to the board clock, reset button, switches and display.

## Interface
- STEP_DIV, 1 — clocks per CPU step tick (1 = step every clock).
- SCAN_DIV, 4 — clocks each display digit stays enabled.
- CLK  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Switch  in  6  [5]=run, [4:2]=register index, [1:0]=display mode.
- Segs  out  8  active-low segments; [7]=dp, [6:0]=g..a.
- En  out  6  active-low one-hot digit enable; bit 0 = rightmost digit.

## Operation
- **Instruction format (16-bit):** op[15:12], rd[11:9], rs[8:6], rt[5:3], imm6[5:0] (sign-extended), imm8[7:0] for J.
- **ALU ops:**
  - 0 ADD rd=rs+rt; 1 SUB rd=rs−rt; 2 AND; 3 OR.
  - 4 ADDI rd=rs+sext(imm6). All arithmetic is mod 2^16.
- **Control ops:**
  - 6 BEQ: if rd==rs, PC=PC+1+sext(imm6).
  - 7 J: PC=imm8.
  - F HALT: PC holds; halted flag set.
- **Other opcodes:** NOP (PC+1).
- **Registers and PC:** r0 reads 0; writes to r0 are ignored. PC is 8-bit and wraps FF→00.
- **ROM (address: instruction):**
  - 0 ADDI r1,r0,1; 1 ADDI r2,r0,1; 2 ADDI r4,r0,10
  - 3 ADD r3,r1,r2; 4 ADD r1,r2,r0; 5 ADD r2,r3,r0
  - 6 ADDI r4,r4,−1; 7 BEQ r4,r0,+1; 8 J 3; 9 HALT
  - all other addresses: HALT.
- **Step condition:** a step executes one instruction when step_tick & Switch[5] & ~halted. When Switch[5]=0 all CPU state is frozen.
- **Display modes** (digits listed 5..0, hex):
  - 00: PC[7:4], PC[3:0], instr[15:12..3:0].
  - 01: register index, blank, reg[Switch[4:2]] as 4 digits.
  - 10: PC (2 digits), current ALU result (4 digits).
  - 11: r1[7:0], r2[7:0], r3[7:0].
- **Glyphs:**
  - 0–F standard hex; blank = all segments off.
  - Codes with dp off: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, B=83, C=C6, D=A1, E=86, F=8E.

## Timing
- **Reset (synchronous):**
  - clears PC=0, all registers=0, halted=0, step and scan counters=0, digit index=0.
  - Segs=8'hFF and En=6'b111111 in the cycle after reset is sampled.
- **Step tick:** asserted for one clock every STEP_DIV clocks, counted from reset release.
- **Single-cycle execution:** one instruction completes per qualifying tick. The register write and PC update take effect on the same edge.
- **Program run time:** from reset with Switch[5]=1 and STEP_DIV=1:
  - the CPU reaches PC=9 after 62 steps;
  - the HALT step sets halted; PC stays 9.
- **Scan:**
  - the digit index advances 0→5→0 every SCAN_DIV clocks;
  - En and Segs are registered, so output lags the index by one clock;
  - the first digit enabled after reset is digit 0 (En=6'b111110).
- **Display refresh:** the display reflects CPU state as of the current clock. A step and a scan change may occur on the same edge.
- **Reset during run:** reset mid-run or while halted restarts the program at PC 0 on the next tick.

## Configuration
- **HALT_DP_EN defined:** Segs[7]=0 (dp lit) on every digit while halted=1.
- **HALT_DP_EN undefined:** Segs[7]=1 always; halted is still maintained internally.

## Test plan
- Reset held 2 clocks → Segs=FF, En=3F. Next clock: En=3E, mode 00 shows "000000"-based instr 4 digits (ROM[0]).
- Switch=6'b111111, STEP_DIV=1:
  - after 3 steps, mode 11 shows r1=01, r2=01, r3=00;
  - after 4 steps, r3=02.
- Run 70 clocks with Switch=6'b100001 (mode 01, reg 0) → PC=9, r0 always 0000. Switch to reg 3 (6'b101101) → digits "3 _ 0090".
- Switch[5]=0 from reset, 20 clocks → PC stays 00; raising Switch[5] resumes stepping from PC 00.
- Scan check with SCAN_DIV=4 → En cycles 3E,3D,3B,37,2F,1F with 4 clocks each, then repeats.
- HALT_DP_EN defined, after halt → Segs[7]=0 on all digits; undefined → Segs[7]=1.
